srambank_ctrl_256x4x40: RTL and testbench

- Upstream request front-end for the 256x4x40 6T bank (1024 words x 40 bits).
- Accepts read/write requests on a valid/ready port and registers them onto the bank's ADDRESS/wd/banksel/read/write pins.
- Captures bank dataout one cycle after each issued read and returns it in order through a small response FIFO with valid/ready backpressure.
- Credit-based issue guarantees a read is only sent to the bank when response storage is reserved, so no read data is ever lost.

---
 rtl/srambank_pkg.sv | 21 ++
 rtl/srambank_rsp_fifo.sv | 65 ++++++
 rtl/srambank_ctrl_256x4x40.sv | 110 +++++++++++
 tb/tb_srambank_ctrl_256x4x40.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srambank_pkg.sv
// Shared types and constants for the 256x4x40 SRAM bank front-end.
package srambank_pkg;

  localparam int SRAMBANK_AW    = 10;
  localparam int SRAMBANK_DW    = 40;
  localparam int SRAMBANK_WORDS = 1 << SRAMBANK_AW;

  typedef struct packed {
    logic                   write;
    logic [SRAMBANK_AW-1:0] addr;
    logic [SRAMBANK_DW-1:0] wdata;
  } srambank_req_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/srambank_rsp_fifo.sv
// Circular response FIFO; push and pop may coincide, including when full.
module srambank_rsp_fifo
  import srambank_pkg::*;
#(
  parameter  int DW    = 40,
  parameter  int DEPTH = 4,
  localparam int CW    = clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = nxt(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = nxt(rd_ptr_q);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/srambank_ctrl_256x4x40.sv
// Request front-end for the 256x4x40 bank: registered issue, one-cycle-late
// read capture, credit-gated acceptance so captured read data always has a slot.
module srambank_ctrl_256x4x40
  import srambank_pkg::*;
#(
  parameter int AW        = SRAMBANK_AW,
  parameter int DW        = SRAMBANK_DW,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] ADDRESS,
  output logic [DW-1:0] wd,
  output logic          banksel,
  output logic          read,
  output logic          write,
  input  logic [DW-1:0] dataout
);

  localparam int CW = clog2(RSP_DEPTH + 1);

  logic          acc, acc_rd, acc_wr, pop;
  logic [CW-1:0] out_q, out_d;
  logic          banksel_q, banksel_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic          cap_pend_q, cap_pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // Credits count every read from acceptance until its response is popped.
  assign req_ready = ~reset & (out_q < CW'(RSP_DEPTH));
  assign acc       = req_valid & req_ready;
  assign acc_rd    = acc & ~req_write;
  assign acc_wr    = acc & req_write;
  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;

  assign banksel = banksel_q;
  assign read    = read_q;
  assign write   = write_q;
  assign ADDRESS = addr_q;
  assign wd      = wd_q;

  always_comb begin
    banksel_d  = acc;
    read_d     = acc_rd;
    write_d    = acc_wr;
    addr_d     = acc ? req_addr : addr_q;
    wd_d       = acc_wr ? req_wdata : wd_q;
    // dataout is valid the cycle after the bank sees read.
    cap_pend_d = read_q;
    out_d      = out_q + CW'(acc_rd) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      banksel_q  <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      cap_pend_q <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      out_q      <= '0;
    end else begin
      banksel_q  <= banksel_d;
      read_q     <= read_d;
      write_q    <= write_d;
      cap_pend_q <= cap_pend_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      out_q      <= out_d;
    end
  end

  srambank_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap_pend_q),
    .din   (dataout),
    .pop   (pop),
    .dout  (rsp_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(cap_pend_q && fifo_full && !pop));
      assert (out_q <= CW'(RSP_DEPTH));
      assert (!(read_q && write_q));
      assert (out_q == CW'(read_q) + CW'(cap_pend_q) + fifo_count);
    end
  end

endmodule

// File: tb/tb_srambank_ctrl_256x4x40.sv
// Scoreboard bench: accepted requests update a reference memory and queue
// expected read data; a monitor compares every presented response in order.
module tb_srambank_ctrl_256x4x40;
  import srambank_pkg::*;

  localparam int AW    = SRAMBANK_AW;
  localparam int DW    = SRAMBANK_DW;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] wd;
  logic          banksel, read, write;
  logic [DW-1:0] dataout;

  always #5 clk = ~clk;

  srambank_ctrl_256x4x40 #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ADDRESS   (ADDRESS),
    .wd        (wd),
    .banksel   (banksel),
    .read      (read),
    .write     (write),
    .dataout   (dataout)
  );

  // Bank: no reset, write at the edge ending an issue cycle, dataout on read.
  logic [DW-1:0] bank_mem [SRAMBANK_WORDS];
  logic [DW-1:0] bank_dout;
  always @(posedge clk) begin
    if (banksel && write) bank_mem[ADDRESS] <= wd;
    if (banksel && read)  bank_dout <= bank_mem[ADDRESS];
  end
  assign dataout = bank_dout;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ref_mem [SRAMBANK_WORDS];
  logic [DW-1:0] exp_q[$];
  int            pop_cyc[$];
  int            rd_pulses = 0;
  int            n_checks  = 0;
  int            n_fail    = 0;
  bit            done;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        check("rsp_has_expect", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("rsp_data", rsp_data, exp_q[0]);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            pop_cyc.push_back(cyc);
          end
        end
      end
      check("rw_exclusive", read & write, 0);
      if (banksel && read) rd_pulses++;
      if (reset) exp_q.delete();
      else if (req_valid && req_ready) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else begin
          exp_q.push_back(ref_mem[req_addr]);
          check("credit_bound", exp_q.size() > DEPTH, 0);
        end
      end
    end
  endtask

  function automatic srambank_req_t mk(input bit w, input int a, input logic [DW-1:0] d);
    srambank_req_t r;
    r.write = w;
    r.addr  = AW'(a);
    r.wdata = d;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge ending the accept cycle.
  task automatic send(input srambank_req_t r, output int acc_cyc, output int waited);
    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    waited    = 0;
    acc_cyc   = -1;
    while (1) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc;
        break;
      end
      if (waited == 100) begin
        check("req_accept_timeout", 0, 1);
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    int ac, wt;
    send(mk(1'b1, a, d), ac, wt);
  endtask

  task automatic rd(input int a);
    int ac, wt;
    send(mk(1'b0, a, '0), ac, wt);
  endtask

  // Read accepted in cycle T must show rsp_valid first in T+3 (FIFO empty).
  task automatic expect_lat();
    @(negedge clk); check("lat_t1", rsp_valid, 0);
    @(negedge clk); check("lat_t2", rsp_valid, 0);
    @(negedge clk); check("lat_t3", rsp_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, ac, wt, idx, rp0, n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    done      = 1'b0;
    fork
      monitor();
      begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
      end
    join_none

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_banksel", banksel, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_address", ADDRESS, 0);
    check("rst_wd", wd, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    check("idle_banksel", banksel, 0);
    @(posedge clk); #1;

    // Single write then read of the top address
    rsp_ready = 1'b1;
    wr(10'h3FF, 40'hA5A5A5A5A5);
    @(negedge clk);
    check("wr_banksel", banksel, 1);
    check("wr_write", write, 1);
    check("wr_read", read, 0);
    check("wr_address", ADDRESS, 10'h3FF);
    check("wr_wd", wd, 40'hA5A5A5A5A5);
    @(posedge clk); #1;
    rd(10'h3FF);
    expect_lat();
    drain();

    // Streaming reads with preloaded data = addr*3
    for (int a = 0; a < 8; a++) wr(a, DW'(a * 3));
    repeat (3) @(posedge clk);
    #1;
    t0 = 0;
    for (int a = 0; a < 8; a++) begin
      send(mk(1'b0, a, '0), ac, wt);
      if (a == 0) t0 = ac;
      check("stream_no_stall", wt, 0);
    end
    drain();
    n = pop_cyc.size();
    check("stream_first_rsp", pop_cyc[n-8], t0 + 3);
    check("stream_last_rsp", pop_cyc[n-1], t0 + 10);

    // Backpressure: credits stop acceptance at DEPTH outstanding reads
    rsp_ready = 1'b0;
    idx = 0;
    rp0 = rd_pulses;
    for (int c = 0; c < 12; c++) begin
      req_valid = (idx < 6);
      req_write = 1'b0;
      req_addr  = AW'(idx);
      @(negedge clk);
      if (req_valid && req_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", idx, 4);
    check("bp_req_ready", req_ready, 0);
    check("bp_read_pulses", rd_pulses - rp0, 4);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      req_valid = 1'b1;
      req_addr  = AW'(idx);
      @(negedge clk);
      if (req_ready) idx++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("bp_all_accepted", idx, 6);
    drain();
    check("bp_total_pulses", rd_pulses - rp0, 6);

    // Write-write-read hazard on one address
    wr(10'h010, 40'h1);
    wr(10'h010, 40'h2);
    rd(10'h010);
    drain();

    // Reset with reads in every pipeline stage
    rsp_ready = 1'b0;
    rd(1); rd(2); rd(3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_stale", rsp_valid, 0);
    end
    @(posedge clk); #1;
    rd(5);
    expect_lat();
    drain();

    // Random mixed traffic with random consumer backpressure
    for (int a = 8; a < 16; a++) wr(a, DW'({$urandom(), $urandom()}));
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(mk($urandom_range(0, 2) == 0, $urandom_range(0, 15),
                  DW'({$urandom(), $urandom()})), ac, wt);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
